// File: rtl/lcd_pkg.sv
// Shared types and panel command constants for the dual-controller 128x64 LCD bus writer.
// Requests are {cs, di, data}; cs bit0 selects the left half (CS1), bit1 the right half (CS2).
package lcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_PULSE = 2'd2,
      ST_HOLD  = 2'd3
   } lcd_state_e;

   typedef struct packed {
      logic [1:0] cs;
      logic       di;
      logic [7:0] data;
   } lcd_req_t;

   localparam int unsigned LCD_REQ_W = 11;

   localparam logic [7:0] LCD_DISPLAY_ON = 8'h3F;
   localparam logic [7:0] LCD_START_LINE = 8'hC0;
   localparam logic [7:0] LCD_SET_PAGE   = 8'hB8;
   localparam logic [7:0] LCD_SET_COL    = 8'h40;

   function automatic logic [7:0] lcd_page_cmd(input logic [2:0] page);
      return LCD_SET_PAGE | {5'd0, page};
   endfunction

   function automatic logic [7:0] lcd_col_cmd(input logic [5:0] col);
      return LCD_SET_COL | {2'd0, col};
   endfunction

endpackage

// File: rtl/lcd_req_fifo.sv
// First-word-fall-through request FIFO: head entry is visible on pop_data_o whenever not empty.
// Full is registered state only, so a same-cycle pop never re-opens a full FIFO.
module lcd_req_fifo
   import lcd_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     push_i,
   input  lcd_req_t push_data_i,
   input  logic     pop_i,
   output lcd_req_t pop_data_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   lcd_req_t      mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full_o     = (count_q == FULL_CNT);
   assign empty_o    = (count_q == '0);
   assign do_push    = push_i && !full_o;
   assign do_pop     = pop_i && !empty_o;
   assign pop_data_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the count gates every read.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/lcd_bus_writer.sv
// Replays queued {cs, di, data} requests as timed LCD bus cycles: SETUP, registered ENABLE
// pulse of PULSE_CYC cycles, then GAP_CYC cycles of hold with the bus unchanged.
module lcd_bus_writer
   import lcd_pkg::*;
#(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned PULSE_CYC = 2,
   parameter int unsigned GAP_CYC   = 2
) (
   input  logic       LCD_CLK,
   input  logic       RESETN,
   // Handshake: a request is taken on a rising edge with REQ_VALID && REQ_READY; REQ_CS/DI/DATA
   // are sampled only then. REQ_READY is !full and never depends on REQ_VALID or on a pop.
   input  logic       REQ_VALID,
   output logic       REQ_READY,
   input  logic [1:0] REQ_CS,
   input  logic       REQ_DI,
   input  logic [7:0] REQ_DATA,
   output logic       BUSY,
   output logic [7:0] LCD_DATA,
   output logic       LCD_ENABLE,
   output logic       LCD_RW,
   output logic       LCD_RSTN,
   output logic       LCD_CS1,
   output logic       LCD_CS2,
   output logic       LCD_DI,
   output lcd_state_e DBG_STATE
);

   localparam int unsigned CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);

   lcd_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       data_q, data_d;
   logic             di_q, di_d;
   logic [1:0]       cs_q, cs_d;
   logic             en_q, en_d;

   lcd_req_t         req_in, head;
   logic             fifo_pop, fifo_full, fifo_empty;
   logic             head_live;

   assign req_in = '{cs: REQ_CS, di: REQ_DI, data: REQ_DATA};

   lcd_req_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i       (LCD_CLK),
      .rst_ni      (RESETN),
      .push_i      (REQ_VALID),
      .push_data_i (req_in),
      .pop_i       (fifo_pop),
      .pop_data_o  (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // An entry addressed to neither half is consumed without producing a bus cycle.
   assign head_live = !fifo_empty && (head.cs != 2'b00);

   always_ff @(posedge LCD_CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         di_q    <= 1'b0;
         cs_q    <= 2'b00;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         di_q    <= di_d;
         cs_q    <= cs_d;
         en_q    <= en_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (head_live) state_d = ST_SETUP;
         ST_SETUP: state_d = ST_PULSE;
         ST_PULSE: if (cnt_q == '0) state_d = ST_HOLD;
         ST_HOLD: begin
            if (cnt_q == '0) state_d = head_live ? ST_SETUP : ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      fifo_pop = 1'b0;
      cnt_d    = cnt_q;
      data_d   = data_q;
      di_d     = di_q;
      cs_d     = cs_q;
      en_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            fifo_pop = !fifo_empty;
            if (head_live) begin
               data_d = head.data;
               di_d   = head.di;
               cs_d   = head.cs;
            end
         end
         ST_SETUP: begin
            en_d  = 1'b1;
            cnt_d = PULSE_LOAD;
         end
         ST_PULSE: begin
            if (cnt_q == '0) begin
               cnt_d = GAP_LOAD;
            end else begin
               en_d  = 1'b1;
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               fifo_pop = !fifo_empty;
               if (head_live) begin
                  data_d = head.data;
                  di_d   = head.di;
                  cs_d   = head.cs;
               end else begin
                  cs_d = 2'b00;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            cs_d = 2'b00;
         end
      endcase
   end

   assign REQ_READY  = !fifo_full;
   assign BUSY       = !fifo_empty || (state_q != ST_IDLE);
   assign LCD_DATA   = data_q;
   assign LCD_ENABLE = en_q;
   assign LCD_RW     = 1'b0;
   assign LCD_RSTN   = RESETN;
   assign LCD_CS1    = cs_q[0];
   assign LCD_CS2    = cs_q[1];
   assign LCD_DI     = di_q;
   assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Bench for lcd_bus_writer: scenario tasks plus a bus monitor that matches every ENABLE pulse
// against the queue of accepted requests and checks pulse width and bus stability.
module tb_lcd_bus_writer;
   import lcd_pkg::*;

   localparam int DEPTH     = 8;
   localparam int PULSE_CYC = 2;
   localparam int GAP_CYC   = 2;
   localparam int PERIOD    = 1 + PULSE_CYC + GAP_CYC;

   logic       LCD_CLK, RESETN;
   logic       REQ_VALID, REQ_READY, REQ_DI;
   logic [1:0] REQ_CS;
   logic [7:0] REQ_DATA, LCD_DATA;
   logic       BUSY, LCD_ENABLE, LCD_RW, LCD_RSTN, LCD_CS1, LCD_CS2, LCD_DI;
   lcd_state_e DBG_STATE;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int pulses       = 0;

   logic [10:0] exp_q[$];
   int          rise_q[$];

   lcd_bus_writer #(
      .DEPTH     (DEPTH),
      .PULSE_CYC (PULSE_CYC),
      .GAP_CYC   (GAP_CYC)
   ) dut (
      .LCD_CLK    (LCD_CLK),
      .RESETN     (RESETN),
      .REQ_VALID  (REQ_VALID),
      .REQ_READY  (REQ_READY),
      .REQ_CS     (REQ_CS),
      .REQ_DI     (REQ_DI),
      .REQ_DATA   (REQ_DATA),
      .BUSY       (BUSY),
      .LCD_DATA   (LCD_DATA),
      .LCD_ENABLE (LCD_ENABLE),
      .LCD_RW     (LCD_RW),
      .LCD_RSTN   (LCD_RSTN),
      .LCD_CS1    (LCD_CS1),
      .LCD_CS2    (LCD_CS2),
      .LCD_DI     (LCD_DI),
      .DBG_STATE  (DBG_STATE)
   );

   // Clock and cycle count
   initial LCD_CLK = 1'b0;
   always #5 LCD_CLK = ~LCD_CLK;
   always @(posedge LCD_CLK) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
      $fatal(1, "watchdog");
   end

   // Bus monitor / scoreboard
   logic        en_prev = 1'b0;
   logic [10:0] cap, obs, expv;
   int          hi_len    = 0;
   int          hold_left = 0;

   always @(negedge LCD_CLK) begin
      if (RESETN !== 1'b1) begin
         en_prev   = 1'b0;
         hi_len    = 0;
         hold_left = 0;
      end else begin
         obs = {LCD_CS2, LCD_CS1, LCD_DI, LCD_DATA};
         if (LCD_ENABLE === 1'b1 && !en_prev) begin
            tests_run++;
            pulses++;
            rise_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL unexpected_enable: bus=%h at cycle %0d, required no pulse", obs, cyc);
            end else begin
               expv = exp_q.pop_front();
               if (obs !== expv) begin
                  tests_failed++;
                  $display("FAIL pulse_content: bus=%h, required %h", obs, expv);
               end
            end
            cap    = obs;
            hi_len = 1;
         end else if (LCD_ENABLE === 1'b1) begin
            hi_len++;
            tests_run++;
            if (obs !== cap) begin
               tests_failed++;
               $display("FAIL stable_high: bus=%h, required %h", obs, cap);
            end
         end else if (en_prev) begin
            tests_run++;
            if (hi_len != PULSE_CYC) begin
               tests_failed++;
               $display("FAIL pulse_width: %0d cycles, required %0d", hi_len, PULSE_CYC);
            end
            hold_left = GAP_CYC;
         end
         if (LCD_ENABLE !== 1'b1 && hold_left > 0) begin
            tests_run++;
            if (obs !== cap) begin
               tests_failed++;
               $display("FAIL stable_hold: bus=%h, required %h", obs, cap);
            end
            hold_left--;
         end
         en_prev = (LCD_ENABLE === 1'b1);
      end
   end

   // Driver: called at a negedge, returns at the negedge after the accepting edge.
   task automatic push(input logic [1:0] cs, input logic di, input logic [7:0] d,
                       output int acc_cyc, output int stalls);
      stalls    = 0;
      acc_cyc   = -1;
      REQ_VALID = 1'b1;
      REQ_CS    = cs;
      REQ_DI    = di;
      REQ_DATA  = d;
      while (REQ_READY !== 1'b1 && stalls < 100) begin
         @(negedge LCD_CLK);
         stalls++;
      end
      if (REQ_READY !== 1'b1) begin
         tests_run++;
         tests_failed++;
         $display("FAIL push_timeout: REQ_READY=%b after %0d cycles, required 1", REQ_READY, stalls);
      end else begin
         @(posedge LCD_CLK);
         if (cs != 2'b00) exp_q.push_back({cs, di, d});
         @(negedge LCD_CLK);
         acc_cyc = cyc;
      end
      REQ_VALID = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int g;
      g = 0;
      while ((BUSY !== 1'b0 || hold_left > 0) && g < 500) begin
         @(negedge LCD_CLK);
         g++;
      end
      tests_run++;
      if (BUSY !== 1'b0 || exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL %s_drain: BUSY=%b pending=%0d, required BUSY=0 pending=0",
                  name, BUSY, exp_q.size());
      end
      @(negedge LCD_CLK);
   endtask

   task automatic test_reset;
      RESETN    = 1'b0;
      REQ_VALID = 1'b0;
      REQ_CS    = 2'b00;
      REQ_DI    = 1'b0;
      REQ_DATA  = 8'h00;
      repeat (3) @(negedge LCD_CLK);
      tests_run++;
      if ({LCD_DATA, LCD_ENABLE, LCD_RW, LCD_CS1, LCD_CS2, LCD_DI, BUSY} !== 14'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs: data=%h en=%b rw=%b cs1=%b cs2=%b di=%b busy=%b, required all 0",
                  LCD_DATA, LCD_ENABLE, LCD_RW, LCD_CS1, LCD_CS2, LCD_DI, BUSY);
      end
      tests_run++;
      if (LCD_RSTN !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_lcd_rstn: %b, required 0", LCD_RSTN);
      end
      #2 RESETN = 1'b1;
      @(negedge LCD_CLK);
      tests_run++;
      if (REQ_READY !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ready: %b, required 1", REQ_READY);
      end
      tests_run++;
      if (BUSY !== 1'b0 || LCD_ENABLE !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_busy: busy=%b en=%b, required 0 0", BUSY, LCD_ENABLE);
      end
      tests_run++;
      if (LCD_RSTN !== 1'b1 || DBG_STATE !== ST_IDLE) begin
         tests_failed++;
         $display("FAIL release_state: rstn=%b state=%0d, required 1 IDLE", LCD_RSTN, DBG_STATE);
      end
   endtask

   // Single write: bus valid from t+1, ENABLE high over [t+2, t+2+PULSE), idle from t+PERIOD+1.
   task automatic test_single;
      int t, s, k;
      logic en_e, cs_e, busy_e;
      push(2'b01, 1'b0, LCD_DISPLAY_ON, t, s);
      for (int n = 0; n < 8; n++) begin
         k      = cyc - t;
         en_e   = (k >= 2) && (k < 2 + PULSE_CYC);
         cs_e   = (k >= 1) && (k < 1 + PERIOD);
         busy_e = (k < 1 + PERIOD);
         tests_run++;
         if ({LCD_ENABLE, LCD_CS1, LCD_CS2, BUSY, LCD_RW} !== {en_e, cs_e, 1'b0, busy_e, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_k%0d: en=%b cs1=%b cs2=%b busy=%b rw=%b, required %b %b 0 %b 0",
                     k, LCD_ENABLE, LCD_CS1, LCD_CS2, BUSY, LCD_RW, en_e, cs_e, busy_e);
         end
         if (k >= 1) begin
            tests_run++;
            if ({LCD_DI, LCD_DATA} !== {1'b0, LCD_DISPLAY_ON}) begin
               tests_failed++;
               $display("FAIL single_bus_k%0d: di=%b data=%h, required 0 %h", k, LCD_DI, LCD_DATA,
                        LCD_DISPLAY_ON);
            end
         end
         @(negedge LCD_CLK);
      end
      tests_run++;
      if (DBG_STATE !== ST_IDLE) begin
         tests_failed++;
         $display("FAIL single_idle: state=%0d, required IDLE", DBG_STATE);
      end
      wait_idle("single");
   endtask

   // Eleven back-to-back pushes: the FIFO fills after the tenth, and the pop two edges later
   // only opens READY for the edge after it, so the eleventh waits exactly two cycles.
   task automatic test_fill;
      int t, s, total;
      total = 0;
      rise_q.delete();
      for (int i = 0; i < 11; i++) begin
         push(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), t, s);
         total += s;
      end
      tests_run++;
      if (total != 2) begin
         tests_failed++;
         $display("FAIL fill_stall: %0d stall cycles, required 2", total);
      end
      wait_idle("fill");
      tests_run++;
      if (rise_q.size() != 11) begin
         tests_failed++;
         $display("FAIL fill_count: %0d pulses, required 11", rise_q.size());
      end else begin
         for (int i = 1; i < 11; i++) begin
            tests_run++;
            if (rise_q[i] - rise_q[i-1] != PERIOD) begin
               tests_failed++;
               $display("FAIL fill_pitch_%0d: %0d cycles, required %0d", i,
                        rise_q[i] - rise_q[i-1], PERIOD);
            end
         end
      end
   endtask

   // A CS=00 entry produces no pulse; it is consumed on the last HOLD cycle, leaving one IDLE cycle.
   task automatic test_discard;
      int t, s, g;
      rise_q.delete();
      push(2'b01, 1'b0, lcd_page_cmd(3'd3), t, s);
      push(2'b00, 1'b1, 8'h22, t, s);
      push(2'b10, 1'b1, lcd_col_cmd(6'd17), t, s);
      g = 0;
      while (rise_q.size() < 2 && g < 40) begin
         tests_run++;
         if (BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL discard_busy: BUSY=%b at cycle %0d, required 1", BUSY, cyc);
         end
         @(negedge LCD_CLK);
         g++;
      end
      tests_run++;
      if (rise_q.size() != 2) begin
         tests_failed++;
         $display("FAIL discard_pulses: %0d pulses, required 2", rise_q.size());
      end else if (rise_q[1] - rise_q[0] != PERIOD + 1) begin
         tests_failed++;
         $display("FAIL discard_spacing: %0d cycles, required %0d", rise_q[1] - rise_q[0], PERIOD + 1);
      end
      wait_idle("discard");
   endtask

   task automatic test_both;
      int t, s, k;
      logic [1:0] cs_e;
      push(2'b11, 1'b1, 8'hA5, t, s);
      for (int n = 0; n < 8; n++) begin
         k    = cyc - t;
         cs_e = ((k >= 1) && (k < 1 + PERIOD)) ? 2'b11 : 2'b00;
         tests_run++;
         if ({LCD_CS2, LCD_CS1} !== cs_e) begin
            tests_failed++;
            $display("FAIL both_cs_k%0d: cs=%b, required %b", k, {LCD_CS2, LCD_CS1}, cs_e);
         end
         if (k >= 1) begin
            tests_run++;
            if ({LCD_DI, LCD_DATA} !== 9'h1A5) begin
               tests_failed++;
               $display("FAIL both_bus_k%0d: di=%b data=%h, required 1 a5", k, LCD_DI, LCD_DATA);
            end
         end
         @(negedge LCD_CLK);
      end
      wait_idle("both");
   endtask

   task automatic test_reset_mid;
      int t, s, g;
      for (int i = 0; i < 4; i++) push(2'b01, 1'b1, 8'h10 + 8'(i), t, s);
      g = 0;
      while (LCD_ENABLE !== 1'b1 && g < 20) begin
         @(negedge LCD_CLK);
         g++;
      end
      tests_run++;
      if (LCD_ENABLE !== 1'b1) begin
         tests_failed++;
         $display("FAIL midreset_pulse: ENABLE=%b, required 1 before reset", LCD_ENABLE);
      end
      #2 RESETN = 1'b0;
      #1;
      tests_run++;
      if ({LCD_ENABLE, LCD_CS1, LCD_CS2, LCD_DATA, LCD_DI, BUSY} !== 13'b0) begin
         tests_failed++;
         $display("FAIL midreset_async: en=%b cs1=%b cs2=%b data=%h di=%b busy=%b, required all 0",
                  LCD_ENABLE, LCD_CS1, LCD_CS2, LCD_DATA, LCD_DI, BUSY);
      end
      exp_q.delete();
      @(negedge LCD_CLK);
      #2 RESETN = 1'b1;
      @(negedge LCD_CLK);
      tests_run++;
      if (REQ_READY !== 1'b1) begin
         tests_failed++;
         $display("FAIL midreset_ready: %b, required 1", REQ_READY);
      end
      for (int n = 0; n < 15; n++) begin
         tests_run++;
         if (BUSY !== 1'b0 || LCD_ENABLE !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_replay: busy=%b en=%b, required 0 0", BUSY, LCD_ENABLE);
         end
         @(negedge LCD_CLK);
      end
   endtask

   task automatic test_random;
      int t, s, gap, live, p0;
      logic [1:0] cs;
      live = 0;
      p0   = pulses;
      for (int i = 0; i < 500; i++) begin
         cs = 2'($urandom_range(0, 3));
         push(cs, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), t, s);
         if (cs != 2'b00) live++;
         gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
         repeat (gap) @(negedge LCD_CLK);
      end
      wait_idle("random");
      tests_run++;
      if (pulses - p0 != live) begin
         tests_failed++;
         $display("FAIL random_pulses: %0d pulses, required %0d", pulses - p0, live);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_discard();
      test_both();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
